// File: rtl/cr_rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings, reset-cause codes
// and a width helper.
package cr_rst_seq_pkg;

    typedef enum logic [2:0] {
        StRst  = 3'd0,
        StStr  = 3'd1,
        StWlk  = 3'd2,
        StHrel = 3'd3,
        StCrel = 3'd4,
        StRun  = 3'd5,
        StCstr = 3'd6
    } rst_state_e;

    typedef enum logic [2:0] {
        CausePor  = 3'd0,
        CauseLock = 3'd1,
        CauseWdt  = 3'd2,
        CauseSw   = 3'd3,
        CauseHad  = 3'd4
    } rst_cause_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cr_rst_sync2.sv
// Two-flop synchroniser for an asynchronous level; synchronous active-high clear.
module cr_rst_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/cr_rst_seq.sv
// Pad-level reset sequencer: stretch, wait for PLL lock, release HAD, then CPU; CPU-only
// warm resets. Define CR_RST_SEQ_LOCK_TIMEOUT_EN to bound the lock wait by LOCK_TIMEOUT.
module cr_rst_seq
    import cr_rst_seq_pkg::*;
#(
    parameter int unsigned STRETCH_CYC  = 16,
    parameter int unsigned HAD_CPU_GAP  = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic       pll_core_cpuclk,
    input  logic       pad_sys_rst,
    input  logic       pll_lock,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       had_sys_rst_req,
    output logic       pad_had_rst_b,
    output logic       pad_cpu_rst_b,
    output logic [2:0] rst_cause,
    output logic       rst_seq_busy,
    output logic       pll_lock_timeout
);

    localparam int unsigned CNT_W = $clog2(max3(STRETCH_CYC, HAD_CPU_GAP, LOCK_TIMEOUT)) + 1;

    logic             lock_s;
    logic             lock_lost;
    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             had_b_q, had_b_d;
    logic             cpu_b_q, cpu_b_d;
    rst_cause_e       cause_q, cause_d;
    logic             busy_q, busy_d;
    logic             wlk_lock_q, wlk_lock_d;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
    logic             timeout_q, timeout_d;
    logic             lock_seen_q, lock_seen_d;
`endif

    cr_rst_sync2 u_lock_sync (
        .clk_i (pll_core_cpuclk),
        .rst_i (pad_sys_rst),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
    // After a timeout exit lock may still be absent; only police lock once it has been seen.
    assign lock_lost = lock_seen_q & ~lock_s;
`else
    assign lock_lost = ~lock_s;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        had_b_d    = had_b_q;
        cpu_b_d    = cpu_b_q;
        cause_d    = cause_q;
        wlk_lock_d = 1'b0;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
        timeout_d   = timeout_q;
        lock_seen_d = lock_seen_q | lock_s;
`endif

        case (state_q)
            StRst: begin
                state_d = StStr;
                cnt_d   = '0;
            end
            StStr: begin
                if (cnt_q == CNT_W'(STRETCH_CYC - 1)) begin
                    state_d = StWlk;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWlk: begin
                // wlk_lock_q remembers lock_s from the previous WLK cycle only
                wlk_lock_d = lock_s;
                if (lock_s && wlk_lock_q) begin
                    state_d = StHrel;
                    cnt_d   = '0;
                    had_b_d = 1'b1;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d   = StHrel;
                    cnt_d     = '0;
                    had_b_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            StHrel: begin
                if (cnt_q == CNT_W'(HAD_CPU_GAP - 1)) begin
                    state_d = StCrel;
                    cnt_d   = '0;
                    cpu_b_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCrel: begin
                state_d = StRun;
                cnt_d   = '0;
            end
            StRun: begin
                if (wdt_rst_req) begin
                    state_d = StCstr;
                    cnt_d   = '0;
                    cpu_b_d = 1'b0;
                    cause_d = CauseWdt;
                end else if (sw_rst_req) begin
                    state_d = StCstr;
                    cnt_d   = '0;
                    cpu_b_d = 1'b0;
                    cause_d = CauseSw;
                end else if (had_sys_rst_req) begin
                    state_d = StCstr;
                    cnt_d   = '0;
                    cpu_b_d = 1'b0;
                    cause_d = CauseHad;
                end
            end
            StCstr: begin
                if (cnt_q == CNT_W'(STRETCH_CYC - 1)) begin
                    state_d = StCrel;
                    cnt_d   = '0;
                    cpu_b_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StRst;
                cnt_d   = '0;
                had_b_d = 1'b0;
                cpu_b_d = 1'b0;
            end
        endcase

        // Lock loss outranks every warm request and restarts the full sequence.
        if (lock_lost && (state_q == StHrel || state_q == StCrel ||
                          state_q == StRun || state_q == StCstr)) begin
            state_d = StStr;
            cnt_d   = '0;
            had_b_d = 1'b0;
            cpu_b_d = 1'b0;
            cause_d = CauseLock;
        end

        busy_d = (state_d != StRun);
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_sys_rst) begin
            state_q     <= StRst;
            cnt_q       <= '0;
            had_b_q     <= 1'b0;
            cpu_b_q     <= 1'b0;
            cause_q     <= CausePor;
            busy_q      <= 1'b1;
            wlk_lock_q  <= 1'b0;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
            timeout_q   <= 1'b0;
            lock_seen_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            had_b_q     <= had_b_d;
            cpu_b_q     <= cpu_b_d;
            cause_q     <= cause_d;
            busy_q      <= busy_d;
            wlk_lock_q  <= wlk_lock_d;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
            timeout_q   <= timeout_d;
            lock_seen_q <= lock_seen_d;
`endif
        end
    end

    assign pad_had_rst_b = had_b_q;
    assign pad_cpu_rst_b = cpu_b_q;
    assign rst_cause     = cause_q;
    assign rst_seq_busy  = busy_q;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
    assign pll_lock_timeout = timeout_q;
`else
    assign pll_lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cr_rst_seq.sv
// Directed bench for cr_rst_seq: expected output snapshots are queued per cycle number and
// compared 1 time unit after each rising edge.
module tb_cr_rst_seq;

    localparam int unsigned STR = 16;
    localparam int unsigned GAP = 4;
    localparam int unsigned TO  = 32;
`ifdef CR_RST_SEQ_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int LATE  = 20;
`else
    localparam bit TO_EN = 1'b0;
    localparam int LATE  = 100;
`endif

    logic       clk = 1'b0;
    logic       pad_sys_rst;
    logic       pll_lock;
    logic       sw_rst_req;
    logic       wdt_rst_req;
    logic       had_sys_rst_req;
    logic       pad_had_rst_b;
    logic       pad_cpu_rst_b;
    logic [2:0] rst_cause;
    logic       rst_seq_busy;
    logic       pll_lock_timeout;

    always #5 clk = ~clk;

    cr_rst_seq #(
        .STRETCH_CYC  (STR),
        .HAD_CPU_GAP  (GAP),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .pll_core_cpuclk  (clk),
        .pad_sys_rst      (pad_sys_rst),
        .pll_lock         (pll_lock),
        .sw_rst_req       (sw_rst_req),
        .wdt_rst_req      (wdt_rst_req),
        .had_sys_rst_req  (had_sys_rst_req),
        .pad_had_rst_b    (pad_had_rst_b),
        .pad_cpu_rst_b    (pad_cpu_rst_b),
        .rst_cause        (rst_cause),
        .rst_seq_busy     (rst_seq_busy),
        .pll_lock_timeout (pll_lock_timeout)
    );

    typedef struct {
        string      tag;
        int         at;
        logic [6:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Snapshot layout: {had_b, cpu_b, cause[2:0], busy, timeout}
    function automatic logic [6:0] o(input logic h, input logic c, input logic [2:0] ca,
                                     input logic b, input logic t);
        return {h, c, ca, b, t};
    endfunction

    task automatic push_exp(input string tag, input int at, input logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        exp_t       e;
        logic [6:0] obs;
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].at == cyc) begin
                e   = sb.pop_front();
                obs = {pad_had_rst_b, pad_cpu_rst_b, rst_cause, rst_seq_busy, pll_lock_timeout};
                n_checks++;
                assert (obs === e.v) else begin
                    n_errors++;
                    $error("FAIL %s @%0d: observed %b expected %b", e.tag, cyc, obs, e.v);
                end
            end
        end
    endtask

    initial begin
        int b;
        int l;
        int h;

        pad_sys_rst     = 1'b1;
        pll_lock        = 1'b1;
        sw_rst_req      = 1'b0;
        wdt_rst_req     = 1'b0;
        had_sys_rst_req = 1'b0;

        // Power-on: lock already present, release after 5 reset cycles.
        push_exp("por_hold", 3, o(0, 0, 0, 1, 0));
        push_exp("por_hold_end", 5, o(0, 0, 0, 1, 0));
        tick(5);
        pad_sys_rst = 1'b0;
        b = cyc;
        push_exp("por_str_wlk", b + 18, o(0, 0, 0, 1, 0));
        push_exp("por_had_rel", b + 19, o(1, 0, 0, 1, 0));
        push_exp("por_gap_end", b + 22, o(1, 0, 0, 1, 0));
        push_exp("por_cpu_rel", b + 23, o(1, 1, 0, 1, 0));
        push_exp("por_run", b + 24, o(1, 1, 0, 0, 0));
        tick(30);

        // Warm: wdt and sw together, wdt wins.
        b = cyc;
        wdt_rst_req = 1'b1;
        sw_rst_req  = 1'b1;
        push_exp("warm_wdt_entry", b + 1, o(1, 0, 2, 1, 0));
        push_exp("warm_wdt_hold", b + 16, o(1, 0, 2, 1, 0));
        push_exp("warm_wdt_crel", b + 17, o(1, 1, 2, 1, 0));
        push_exp("warm_wdt_run", b + 18, o(1, 1, 2, 0, 0));
        tick(1);
        wdt_rst_req = 1'b0;
        sw_rst_req  = 1'b0;
        tick(20);

        // Single-cycle sw and had requests.
        for (int k = 0; k < 2; k++) begin
            b = cyc;
            sw_rst_req      = (k == 0);
            had_sys_rst_req = (k == 1);
            push_exp(k == 0 ? "warm_sw_entry" : "warm_had_entry", b + 1,
                     o(1, 0, (k == 0) ? 3'd3 : 3'd4, 1, 0));
            push_exp(k == 0 ? "warm_sw_run" : "warm_had_run", b + 18,
                     o(1, 1, (k == 0) ? 3'd3 : 3'd4, 0, 0));
            tick(1);
            sw_rst_req      = 1'b0;
            had_sys_rst_req = 1'b0;
            tick(20);
        end

        // A request level still high when RUN returns retriggers.
        b = cyc;
        had_sys_rst_req = 1'b1;
        push_exp("retrig_run", b + 18, o(1, 1, 4, 0, 0));
        push_exp("retrig_again", b + 19, o(1, 0, 4, 1, 0));
        push_exp("retrig_run2", b + 36, o(1, 1, 4, 0, 0));
        tick(19);
        had_sys_rst_req = 1'b0;
        tick(20);

        // Lock drop in RUN; sw request during the replayed stretch is ignored.
        b = cyc;
        pll_lock = 1'b0;
        push_exp("ldrop_pre", b + 2, o(1, 1, 4, 0, 0));
        push_exp("ldrop_str", b + 3, o(0, 0, 1, 1, 0));
        push_exp("ldrop_sw_ign", b + 8, o(0, 0, 1, 1, 0));
        push_exp("ldrop_wlk", b + 20, o(0, 0, 1, 1, 0));
        push_exp("ldrop_had_rel", b + 21, o(1, 0, 1, 1, 0));
        push_exp("ldrop_cpu_rel", b + 25, o(1, 1, 1, 1, 0));
        push_exp("ldrop_run", b + 26, o(1, 1, 1, 0, 0));
        tick(3);
        pll_lock = 1'b1;
        tick(1);
        sw_rst_req = 1'b1;
        tick(4);
        sw_rst_req = 1'b0;
        tick(22);

        // Late lock after a fresh reset.
        pad_sys_rst = 1'b1;
        pll_lock    = 1'b0;
        push_exp("late_rst", cyc + 2, o(0, 0, 0, 1, 0));
        tick(3);
        pad_sys_rst = 1'b0;
        b = cyc;
        l = b + LATE;
        push_exp("late_wlk_entry", b + 17, o(0, 0, 0, 1, 0));
        push_exp("late_wait", b + LATE - 1, o(0, 0, 0, 1, 0));
        push_exp("late_pre_had", l + 3, o(0, 0, 0, 1, 0));
        push_exp("late_had_rel", l + 4, o(1, 0, 0, 1, 0));
        push_exp("late_cpu_rel", l + 8, o(1, 1, 0, 1, 0));
        push_exp("late_run", l + 9, o(1, 1, 0, 0, 0));
        tick(LATE);
        pll_lock = 1'b1;
        tick(12);

        // No lock: timeout exit (feature on) or indefinite wait (feature off), then a
        // reset pulse in HREL.
        pad_sys_rst = 1'b1;
        pll_lock    = 1'b0;
        tick(2);
        pad_sys_rst = 1'b0;
        b = cyc;
        if (TO_EN) begin
            h = b + 17 + TO;
            push_exp("to_pre", h - 1, o(0, 0, 0, 1, 0));
            push_exp("to_exit", h, o(1, 0, 0, 1, 1));
            tick(h - cyc);
        end else begin
            push_exp("nto_wait", b + 17 + TO, o(0, 0, 0, 1, 0));
            push_exp("nto_hold", b + 200, o(0, 0, 0, 1, 0));
            tick(200);
            pll_lock = 1'b1;
            h = cyc + 4;
            push_exp("nto_had_rel", h, o(1, 0, 0, 1, 0));
            tick(4);
        end
        pad_sys_rst = 1'b1;
        push_exp("hrel_rst_pulse", h + 1, o(0, 0, 0, 1, 0));
        tick(1);
        pad_sys_rst = 1'b0;
        tick(3);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
